// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the test-pattern mode type for the VGA pattern controller.
package vga_timing_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int CNT_W = 10;
   localparam int BAR_W = 80;

   typedef enum logic [1:0] {
      PAT_XOR   = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_RAMP  = 2'd2,
      PAT_WHITE = 2'd3
   } pat_mode_e;

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical pixel counters with combinational blank, sync and frame strobes.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VIS,
   parameter int H_FRONT   = H_FP,
   parameter int H_SYNC_W  = H_SYNC,
   parameter int H_BACK    = H_BP,
   parameter int V_VISIBLE = V_VIS,
   parameter int V_FRONT   = V_FP,
   parameter int V_SYNC_W  = V_SYNC,
   parameter int V_BACK    = V_BP
)(
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] h,
   output logic [7:0]       v_lo,
   output logic             hblank,
   output logic             vblank,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_start,
   output logic             frame_end
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC_W);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC_W);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;

   always_comb begin
      h_d = h_q + CNT_W'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h           = h_q;
   assign v_lo        = v_q[7:0];
   assign hblank      = (h_q >= H_VIS_L);
   assign vblank      = (v_q >= V_VIS_L);
   assign hsync       = !((h_q >= HS_START) && (h_q < HS_END));
   assign vsync       = !((v_q >= VS_START) && (v_q < VS_END));
   assign frame_start = (h_q == '0) && (v_q == '0);
   assign frame_end   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_pattern_controller.sv
// VGA timing plus selectable test pattern, all outputs in one aligned register stage.
// Optional frame-counter animation is built when VGA_PATTERN_ANIM_EN is defined.
module vga_pattern_controller
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VIS,
   parameter int H_FRONT   = H_FP,
   parameter int H_SYNC_W  = H_SYNC,
   parameter int H_BACK    = H_BP,
   parameter int V_VISIBLE = V_VIS,
   parameter int V_FRONT   = V_FP,
   parameter int V_SYNC_W  = V_SYNC,
   parameter int V_BACK    = V_BP
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   output logic       hsync,
   output logic       vsync,
   output logic       hblank,
   output logic       vblank,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b
);

   logic [CNT_W-1:0] h;
   logic [7:0]       v_lo;
   logic             hblank_c, vblank_c, hsync_c, vsync_c;
   logic             frame_start, frame_end;

   vga_sync_gen #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC_W  (H_SYNC_W),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC_W  (V_SYNC_W),
      .V_BACK    (V_BACK)
   ) u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .h           (h),
      .v_lo        (v_lo),
      .hblank      (hblank_c),
      .vblank      (vblank_c),
      .hsync       (hsync_c),
      .vsync       (vsync_c),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   // armed_q stays low for the first frame after reset so that frame shows pattern 0.
   logic      armed_q, armed_d;
   pat_mode_e mode_q, mode_d, mode_sel;
   logic      capture;

   always_comb begin
      armed_d  = armed_q | frame_end;
      capture  = frame_start & armed_q;
      mode_sel = capture ? pat_mode_e'(mode) : mode_q;
      mode_d   = mode_sel;
   end

   logic [7:0] anim_off;
   logic [2:0] bar_off;

`ifdef VGA_PATTERN_ANIM_EN
   logic [7:0] fc_q, fc_d;

   always_comb begin
      fc_d = frame_end ? fc_q + 8'd1 : fc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fc_q <= '0;
      else        fc_q <= fc_d;
   end

   assign anim_off = fc_q;
   assign bar_off  = fc_q[7:5];
`else
   assign anim_off = 8'd0;
   assign bar_off  = 3'd0;
`endif

   logic [2:0] bar_k;
   logic [7:0] r_d, g_d, b_d;

   always_comb begin
      bar_k = '0;
      for (int i = 1; i < 8; i++) begin
         if (h >= CNT_W'(BAR_W * i)) bar_k = 3'(i);
      end
      bar_k = bar_k + bar_off;

      r_d = 8'h00;
      g_d = 8'h00;
      b_d = 8'h00;
      if (!(hblank_c || vblank_c)) begin
         case (mode_sel)
            PAT_XOR: begin
               r_d = h[7:0] + anim_off;
               g_d = v_lo + anim_off;
               b_d = h[7:0] ^ v_lo;
            end
            PAT_BARS: begin
               r_d = {8{bar_k[2]}};
               g_d = {8{bar_k[1]}};
               b_d = {8{bar_k[0]}};
            end
            PAT_RAMP: begin
               r_d = h[9:2];
               g_d = h[9:2];
               b_d = h[9:2];
            end
            default: begin
               r_d = 8'hFF;
               g_d = 8'hFF;
               b_d = 8'hFF;
            end
         endcase
      end
   end

   logic       hsync_q, vsync_q, hblank_q, vblank_q;
   logic [7:0] r_q, g_q, b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q  <= 1'b0;
         mode_q   <= PAT_XOR;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         r_q      <= 8'h00;
         g_q      <= 8'h00;
         b_q      <= 8'h00;
      end else begin
         armed_q  <= armed_d;
         mode_q   <= mode_d;
         hsync_q  <= hsync_c;
         vsync_q  <= vsync_c;
         hblank_q <= hblank_c;
         vblank_q <= vblank_c;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
      end
   end

   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign hblank = hblank_q;
   assign vblank = vblank_q;
   assign r      = r_q;
   assign g      = g_q;
   assign b      = b_q;

endmodule

// File: tb/tb_vga_pattern_controller.sv
// Directed bench for vga_pattern_controller; full horizontal timing, vertical timing shortened to 8 lines per frame.
module tb_vga_pattern_controller;

   localparam int HT    = 800;
   localparam int VVIS  = 4;
   localparam int VFP   = 1;
   localparam int VSW   = 2;
   localparam int VBP   = 1;
   localparam int VT    = VVIS + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode;
   logic       hsync, vsync, hblank, vblank;
   logic [7:0] r, g, b;

   int n_vec;
   int n_err;
   int cur_pix;

   vga_pattern_controller #(
      .V_VISIBLE (VVIS),
      .V_FRONT   (VFP),
      .V_SYNC_W  (VSW),
      .V_BACK    (VBP)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode   (mode),
      .hsync  (hsync),
      .vsync  (vsync),
      .hblank (hblank),
      .vblank (vblank),
      .r      (r),
      .g      (g),
      .b      (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs visible after this returns belong to linear pixel cur_pix.
   task automatic advance(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cur_pix++;
      end
   endtask

   task automatic seek(input int target);
      if (target > cur_pix) advance(target - cur_pix);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cur_pix = 0;
   endtask

   task automatic test_reset();
      logic [23:0] rgb;
      rst_n = 1'b1;
      mode  = 2'd0;
      repeat (300) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      rgb = {r, g, b};
      n_vec++;
      if ({hsync, vsync, hblank, vblank} !== 4'b1111) begin
         n_err++;
         $display("FAIL reset_flags_async: got %b want 1111", {hsync, vsync, hblank, vblank});
      end
      n_vec++;
      if (rgb !== 24'h000000) begin
         n_err++;
         $display("FAIL reset_rgb_async: got %06h want 000000", rgb);
      end
      repeat (5) @(posedge clk);
      #1;
      rgb = {r, g, b};
      n_vec++;
      if ({hsync, vsync, hblank, vblank, rgb} !== {4'b1111, 24'h000000}) begin
         n_err++;
         $display("FAIL reset_held: got %b/%06h want 1111/000000", {hsync, vsync, hblank, vblank}, rgb);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cur_pix = 0;
      rgb = {r, g, b};
      n_vec++;
      if ({hsync, vsync, hblank, vblank, rgb} !== {4'b1100, 24'h000000}) begin
         n_err++;
         $display("FAIL first_pixel: got %b/%06h want 1100/000000", {hsync, vsync, hblank, vblank}, rgb);
      end
      // Mode change inside the first frame must not show until the frame wraps.
      mode = 2'd3;
      seek(2 * HT + 5);
      rgb = {r, g, b};
      n_vec++;
      if (rgb !== 24'h050207) begin
         n_err++;
         $display("FAIL first_frame_pat0: got %06h want 050207", rgb);
      end
      $display("test_reset done at pixel %0d", cur_pix);
   endtask

   task automatic test_timing();
      int hs_fall[$];
      int hs_rise[$];
      int vs_fall[$];
      int vs_rise[$];
      int hb_first, vb_first, got;
      logic hs_prev, vs_prev;
      mode = 2'd0;
      reset_dut();
      hb_first = -1;
      vb_first = -1;
      hs_prev  = hsync;
      vs_prev  = vsync;
      for (int i = 0; i < 2 * FRAME + HT; i++) begin
         advance(1);
         if (hs_prev && !hsync) hs_fall.push_back(cur_pix);
         if (!hs_prev && hsync) hs_rise.push_back(cur_pix);
         if (vs_prev && !vsync) vs_fall.push_back(cur_pix);
         if (!vs_prev && vsync) vs_rise.push_back(cur_pix);
         if (hblank && hb_first < 0) hb_first = cur_pix;
         if (vblank && vb_first < 0) vb_first = cur_pix;
         hs_prev = hsync;
         vs_prev = vsync;
      end
      got = (hs_fall.size() > 0) ? hs_fall[0] : -1;
      n_vec++;
      if (got !== 656) begin
         n_err++;
         $display("FAIL hsync_fall_offset: got %0d want 656", got);
      end
      got = (hs_fall.size() > 0 && hs_rise.size() > 0) ? hs_rise[0] - hs_fall[0] : -1;
      n_vec++;
      if (got !== 96) begin
         n_err++;
         $display("FAIL hsync_low_width: got %0d want 96", got);
      end
      got = (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1;
      n_vec++;
      if (got !== HT) begin
         n_err++;
         $display("FAIL hsync_period: got %0d want %0d", got, HT);
      end
      got = (vs_fall.size() > 0) ? vs_fall[0] : -1;
      n_vec++;
      if (got !== (VVIS + VFP) * HT) begin
         n_err++;
         $display("FAIL vsync_fall_offset: got %0d want %0d", got, (VVIS + VFP) * HT);
      end
      got = (vs_fall.size() > 0 && vs_rise.size() > 0) ? vs_rise[0] - vs_fall[0] : -1;
      n_vec++;
      if (got !== 1600) begin
         n_err++;
         $display("FAIL vsync_low_width: got %0d want 1600", got);
      end
      got = (vs_fall.size() > 1) ? vs_fall[1] - vs_fall[0] : -1;
      n_vec++;
      if (got !== FRAME) begin
         n_err++;
         $display("FAIL frame_period: got %0d want %0d", got, FRAME);
      end
      n_vec++;
      if (hb_first !== 640) begin
         n_err++;
         $display("FAIL hblank_start: got %0d want 640", hb_first);
      end
      n_vec++;
      if (vb_first !== VVIS * HT) begin
         n_err++;
         $display("FAIL vblank_start: got %0d want %0d", vb_first, VVIS * HT);
      end
      $display("test_timing done: %0d hsync falls, %0d vsync falls", hs_fall.size(), vs_fall.size());
   endtask

   task automatic test_bars();
      int          px   [8];
      logic [23:0] want [8];
      logic [23:0] rgb;
      px   = '{0, 79, 80, 159, 559, 560, 639, 640};
      want = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF,
               24'hFFFF00, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
      mode = 2'd1;
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         seek(FRAME + px[i]);
         rgb = {r, g, b};
         n_vec++;
         if (rgb !== want[i]) begin
            n_err++;
            $display("FAIL bars_px%0d: got %06h want %06h", px[i], rgb, want[i]);
         end
      end
      n_vec++;
      if (hblank !== 1'b1) begin
         n_err++;
         $display("FAIL bars_hblank_640: got %b want 1", hblank);
      end
      $display("test_bars done at pixel %0d", cur_pix);
   endtask

   task automatic test_mode_latch_and_blank();
      logic [23:0] rgb, want;
      int          bad, hh, vv;
      mode = 2'd0;
      reset_dut();
      seek(FRAME + 2 * HT);
      mode = 2'd3;
      seek(FRAME + 2 * HT + 5);
      rgb = {r, g, b};
      n_vec++;
      if (rgb !== 24'h050207) begin
         n_err++;
         $display("FAIL latch_same_frame_a: got %06h want 050207", rgb);
      end
      seek(FRAME + 3 * HT + 10);
      rgb = {r, g, b};
      n_vec++;
      if (rgb !== 24'h0A0309) begin
         n_err++;
         $display("FAIL latch_same_frame_b: got %06h want 0A0309", rgb);
      end
      seek(2 * FRAME);
      rgb = {r, g, b};
      n_vec++;
      if (rgb !== 24'hFFFFFF) begin
         n_err++;
         $display("FAIL latch_next_frame_00: got %06h want FFFFFF", rgb);
      end
      // Whole-frame blanking scan with mode 3 held.
      bad = 0;
      for (int p = 2 * FRAME + 1; p < 3 * FRAME; p++) begin
         seek(p);
         hh   = p % HT;
         vv   = (p / HT) % VT;
         want = (hh < 640 && vv < VVIS) ? 24'hFFFFFF : 24'h000000;
         if ({r, g, b} !== want) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL blank_scan: got %0d bad pixels want 0", bad);
      end
      $display("test_mode_latch_and_blank done at pixel %0d", cur_pix);
   endtask

   task automatic test_anim();
      logic [23:0] rgb;
      logic [23:0] want [3];
`ifdef VGA_PATTERN_ANIM_EN
      want = '{24'h050005, 24'h060105, 24'h070205};
`else
      want = '{24'h050005, 24'h050005, 24'h050005};
`endif
      mode = 2'd0;
      reset_dut();
      for (int f = 0; f < 3; f++) begin
         seek(f * FRAME + 5);
         rgb = {r, g, b};
         n_vec++;
         if (rgb !== want[f]) begin
            n_err++;
            $display("FAIL anim_frame%0d: got %06h want %06h", f, rgb, want[f]);
         end
      end
      $display("test_anim done at pixel %0d", cur_pix);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cur_pix = 0;
      rst_n   = 1'b0;
      mode    = 2'd0;
      test_reset();
      test_timing();
      test_bars();
      test_mode_latch_and_blank();
      test_anim();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
